conv1_core: RTL and testbench

First convolution layer of the MNIST inference pipeline. It reads one 28×28 8-bit grayscale image from a synchronous-read image ROM (784 bytes). It computes a 3×3 valid convolution for 3 fixed-weight output channels, then applies ReLU and saturation. It writes 3×26×26 = 2028 unsigned 12-bit feature values into a synchronous-write output RAM for the next layer.

---
 rtl/conv1_pkg.sv | 56 +++++
 rtl/conv1_acc.sv | 50 +++++
 rtl/conv1_core.sv | 160 ++++++++++++++++
 tb/tb_conv1_core.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/conv1_pkg.sv
// Shared constants, kernel weights, FSM encoding and arithmetic helpers for the
// first MNIST convolution layer.
package conv1_pkg;

  localparam int IMG_W   = 28;
  localparam int OUT_DIM = 26;
  localparam int K       = 3;
  localparam int N_CH    = 3;
  localparam int CH_SIZE = 676;
  localparam int TAPS    = 9;
  localparam int ACC_W   = 16;
  localparam int WGT_W   = 5;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_READ  = 3'd1,
    ST_TAIL  = 3'd2,
    ST_WRITE = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  // Row-major 3x3 kernels; 5 bits wide because the Laplacian centre (+8) does not fit 4-bit signed.
  localparam logic signed [WGT_W-1:0] W [N_CH][TAPS] = '{
    '{ 5'sd1,  5'sd1,  5'sd1,  5'sd1,  5'sd1,  5'sd1,  5'sd1,  5'sd1,  5'sd1},
    '{ 5'sd0,  5'sd0,  5'sd0,  5'sd0,  5'sd1,  5'sd0,  5'sd0,  5'sd0,  5'sd0},
    '{-5'sd1, -5'sd1, -5'sd1, -5'sd1,  5'sd8, -5'sd1, -5'sd1, -5'sd1, -5'sd1}
  };

  function automatic logic [11:0] relu_sat(input logic signed [ACC_W-1:0] acc);
    logic [11:0] res;
    if (acc < 16'sd0) begin
      res = 12'd0;
    end else if (acc > 16'sd4095) begin
      res = 12'd4095;
    end else begin
      res = acc[11:0];
    end
    return res;
  endfunction

  function automatic logic [9:0] rom_addr(input logic [4:0] row, input logic [4:0] col,
                                          input logic [3:0] tap, input logic [9:0] pitch);
    logic [9:0] ky;
    logic [9:0] kx;
    if (tap >= 4'd6) begin
      ky = 10'd2;
    end else if (tap >= 4'd3) begin
      ky = 10'd1;
    end else begin
      ky = 10'd0;
    end
    kx = 10'(tap) - 10'd3 * ky;
    return (10'(row) + ky) * pitch + 10'(col) + kx;
  endfunction

endpackage

// File: rtl/conv1_acc.sv
// Three parallel multiply-accumulate channels plus the ReLU/saturate output mux
// for one output pixel.
module conv1_acc (
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        enable,
  input  logic [7:0]  pixel,
  input  logic [3:0]  tap,
  input  logic [1:0]  sel,
  output logic [11:0] result
);
  import conv1_pkg::*;

  logic signed [ACC_W-1:0] acc_r [N_CH];
  logic signed [ACC_W-1:0] sum_s [N_CH];
  logic signed [ACC_W-1:0] pix_s;

  // Sum includes the tap arriving this cycle so the last tap's total is usable immediately.
  always_comb begin
    sum_s = '{default: {ACC_W{1'b0}}};
    pix_s = $signed({8'd0, pixel});
    for (int ch = 0; ch < N_CH; ch++) begin
      if (enable) begin
        sum_s[ch] = acc_r[ch] + pix_s *
                    $signed({{(ACC_W-WGT_W){W[ch][tap][WGT_W-1]}}, W[ch][tap]});
      end else begin
        sum_s[ch] = acc_r[ch];
      end
    end
    case (sel)
      2'd0:    result = relu_sat(sum_s[0]);
      2'd1:    result = relu_sat(sum_s[1]);
      2'd2:    result = relu_sat(sum_s[2]);
      default: result = 12'd0;
    endcase
  end

  // Accumulator registers, cleared once per output pixel.
  always_ff @(posedge clk) begin
    for (int ch = 0; ch < N_CH; ch++) begin
      if (rst || clear) begin
        acc_r[ch] <= {ACC_W{1'b0}};
      end else begin
        acc_r[ch] <= sum_s[ch];
      end
    end
  end

endmodule

// File: rtl/conv1_core.sv
// 3x3 valid convolution over a 28x28 image for three fixed kernels: FSM, raster
// counters and ROM/RAM address generation around the conv1_acc datapath.
module conv1_core #(
  parameter int IMG_W  = conv1_pkg::IMG_W,
  parameter int K      = conv1_pkg::K,
  parameter int N_CH   = conv1_pkg::N_CH,
  parameter int DIN_W  = 8,
  parameter int DOUT_W = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              upstream_busy,
  input  logic [DIN_W-1:0]  data_in,
  output logic [9:0]        raddr,
  output logic              ren,
  output logic [10:0]       waddr,
  output logic              wen,
  output logic [DOUT_W-1:0] data_out
);
  import conv1_pkg::*;

  localparam logic [3:0]  LAST_TAP  = 4'(K * K - 1);
  localparam logic [1:0]  LAST_CH   = 2'(N_CH - 1);
  localparam logic [4:0]  LAST_POS  = 5'(OUT_DIM - 1);
  localparam logic [9:0]  ROW_PITCH = 10'(IMG_W);
  localparam logic [10:0] OUT_PITCH = 11'(OUT_DIM);
  localparam logic [10:0] CH_STEP   = 11'(CH_SIZE);

  state_t      state_r;
  logic [4:0]  row_r;
  logic [4:0]  col_r;
  logic [3:0]  tap_r;
  logic [3:0]  data_tap_r;
  logic [1:0]  ch_r;
  logic [1:0]  sel_s;
  logic        rvalid_r;
  logic        clear_s;
  logic [11:0] result_s;

  conv1_acc u_acc (
    .clk    (clk),
    .rst    (rst),
    .clear  (clear_s),
    .enable (rvalid_r),
    .pixel  (data_in),
    .tap    (data_tap_r),
    .sel    (sel_s),
    .result (result_s)
  );

  // Clear on the first tap of a pixel; select the channel being written on the next edge.
  always_comb begin
    clear_s = 1'b0;
    sel_s   = 2'd0;
    case (state_r)
      ST_READ:  clear_s = (tap_r == 4'd0);
      ST_TAIL:  sel_s   = 2'd0;
      ST_WRITE: sel_s   = ch_r + 2'd1;
      default: begin
        clear_s = 1'b0;
        sel_s   = 2'd0;
      end
    endcase
  end

  // ROM data lags the request by one cycle; remember which tap it belongs to.
  always_ff @(posedge clk) begin
    if (rst) begin
      rvalid_r   <= 1'b0;
      data_tap_r <= 4'd0;
    end else begin
      rvalid_r   <= ren;
      data_tap_r <= tap_r;
    end
  end

  // Main sequencer: raster walk over output pixels with registered ROM/RAM strobes.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= ST_IDLE;
      row_r    <= 5'd0;
      col_r    <= 5'd0;
      tap_r    <= 4'd0;
      ch_r     <= 2'd0;
      ren      <= 1'b0;
      raddr    <= 10'd0;
      wen      <= 1'b0;
      waddr    <= 11'd0;
      data_out <= {DOUT_W{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          wen <= 1'b0;
          if (!upstream_busy) begin
            state_r <= ST_READ;
            row_r   <= 5'd0;
            col_r   <= 5'd0;
            tap_r   <= 4'd0;
            ren     <= 1'b1;
            raddr   <= 10'd0;
          end else begin
            ren <= 1'b0;
          end
        end
        ST_READ: begin
          if (tap_r == LAST_TAP) begin
            state_r <= ST_TAIL;
            ren     <= 1'b0;
          end else begin
            tap_r <= tap_r + 4'd1;
            ren   <= 1'b1;
            raddr <= rom_addr(row_r, col_r, tap_r + 4'd1, ROW_PITCH);
          end
        end
        ST_TAIL: begin
          state_r  <= ST_WRITE;
          ch_r     <= 2'd0;
          wen      <= 1'b1;
          waddr    <= 11'(row_r) * OUT_PITCH + 11'(col_r);
          data_out <= result_s;
        end
        ST_WRITE: begin
          if (ch_r == LAST_CH) begin
            wen <= 1'b0;
            if (row_r == LAST_POS && col_r == LAST_POS) begin
              state_r <= ST_DONE;
            end else begin
              state_r <= ST_READ;
              tap_r   <= 4'd0;
              ren     <= 1'b1;
              if (col_r == LAST_POS) begin
                col_r <= 5'd0;
                row_r <= row_r + 5'd1;
                raddr <= rom_addr(row_r + 5'd1, 5'd0, 4'd0, ROW_PITCH);
              end else begin
                col_r <= col_r + 5'd1;
                raddr <= rom_addr(row_r, col_r + 5'd1, 4'd0, ROW_PITCH);
              end
            end
          end else begin
            ch_r     <= ch_r + 2'd1;
            wen      <= 1'b1;
            waddr    <= waddr + CH_STEP;
            data_out <= result_s;
          end
        end
        ST_DONE: begin
          ren <= 1'b0;
          wen <= 1'b0;
        end
        default: begin
          state_r <= ST_IDLE;
          ren     <= 1'b0;
          wen     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_conv1_core.sv
// Scoreboard bench for conv1_core: image ROM and output RAM models, a direct
// convolution golden model, and directed images with hand-computed spot values.
module tb_conv1_core;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        upstream_busy = 1'b1;
  logic [7:0]  data_in = 8'd0;
  logic [9:0]  raddr;
  logic        ren;
  logic [10:0] waddr;
  logic        wen;
  logic [11:0] data_out;

  conv1_core dut (
    .clk           (clk),
    .rst           (rst),
    .upstream_busy (upstream_busy),
    .data_in       (data_in),
    .raddr         (raddr),
    .ren           (ren),
    .waddr         (waddr),
    .wen           (wen),
    .data_out      (data_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    int addr;
    int data;
  } exp_t;

  exp_t exp_q[$];
  int   img  [784];
  int   mem  [2048];
  int   wcnt [2048];
  int   wts  [3][9];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_errors = 0;
  int   n_writes, first_ren_cyc, first_wen_cyc, last_wen_cyc, first_raddr;
  bit   seen_ren, seen_wen, quiet;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // ROM: synchronous read, data one cycle after ren.
  always @(posedge clk) begin
    if (ren) data_in <= 8'(img[raddr]);
    cyc <= cyc + 1;
  end

  function automatic int golden(int ch, int r, int c);
    int s = 0;
    for (int k = 0; k < 9; k++) s += wts[ch][k] * img[(r + k / 3) * 28 + c + k % 3];
    if (s < 0) s = 0;
    if (s > 4095) s = 4095;
    return s;
  endfunction

  task automatic push_expected();
    for (int r = 0; r < 26; r++)
      for (int c = 0; c < 26; c++)
        for (int ch = 0; ch < 3; ch++) begin
          exp_t e;
          e.addr = ch * 676 + r * 26 + c;
          e.data = golden(ch, r, c);
          exp_q.push_back(e);
        end
  endtask

  task automatic reset_mon();
    n_writes = 0; seen_ren = 0; seen_wen = 0;
    first_ren_cyc = -1; first_wen_cyc = -1; last_wen_cyc = -1; first_raddr = -1;
    for (int a = 0; a < 2048; a++) begin
      mem[a] = -1;
      wcnt[a] = 0;
    end
  endtask

  // Monitor: pops the scoreboard on every RAM write, checks quiet windows.
  initial begin
    forever begin
      exp_t e;
      @(negedge clk);
      if (ren && !seen_ren) begin
        seen_ren = 1; first_ren_cyc = cyc; first_raddr = int'(raddr);
      end
      if (wen) begin
        if (!seen_wen) begin
          seen_wen = 1; first_wen_cyc = cyc;
        end
        last_wen_cyc = cyc;
        n_writes++;
        mem[waddr] = int'(data_out);
        wcnt[waddr]++;
        if (exp_q.size() == 0) begin
          n_checks++; n_errors++;
          $display("FAIL extra_write: got write addr %0d data %0d, expected no write", waddr, data_out);
        end else begin
          e = exp_q.pop_front();
          chk("wr_addr", int'(waddr), e.addr);
          chk("wr_data", int'(data_out), e.data);
        end
      end
      if (quiet) begin
        chk("quiet_ren", int'(ren), 0);
        chk("quiet_wen", int'(wen), 0);
      end
    end
  end

  task automatic release_busy(output int rel);
    upstream_busy = 1'b0;
    rel = cyc;
    repeat (5) @(posedge clk);
    #1 upstream_busy = 1'b1;
  endtask

  task automatic run_image(input string tag, input int hold, input int abort_at);
    int rel;
    int bad;
    rst = 1'b1; upstream_busy = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    exp_q.delete(); reset_mon(); push_expected();
    quiet = 1;
    repeat (hold) @(posedge clk);
    #1 quiet = 0;
    release_busy(rel);
    if (abort_at > 0) begin
      repeat (abort_at - 5) @(posedge clk);
      #1 rst = 1'b1; upstream_busy = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk({tag, "_rst_ren"}, int'(ren), 0);
      chk({tag, "_rst_wen"}, int'(wen), 0);
      chk({tag, "_rst_raddr"}, int'(raddr), 0);
      chk({tag, "_rst_waddr"}, int'(waddr), 0);
      chk({tag, "_rst_dout"}, int'(data_out), 0);
      chk({tag, "_partial"}, int'(n_writes > 0), 1);
      exp_q.delete(); reset_mon(); push_expected();
      repeat (3) @(posedge clk);
      #1 release_busy(rel);
    end
    for (int i = 0; i < 10000 && n_writes < 2028; i++) @(posedge clk);
    @(negedge clk);
    chk({tag, "_writes"}, n_writes, 2028);
    chk({tag, "_first_ren"}, first_ren_cyc, rel + 1);
    chk({tag, "_first_raddr"}, first_raddr, 0);
    chk({tag, "_wen_lat"}, first_wen_cyc - first_ren_cyc, 10);
    chk({tag, "_span"}, last_wen_cyc - first_ren_cyc + 1, 8788);
    chk({tag, "_sb_empty"}, exp_q.size(), 0);
    bad = 0;
    for (int a = 0; a < 2048; a++)
      if ((a < 2028) ? (wcnt[a] != 1) : (wcnt[a] != 0)) bad++;
    chk({tag, "_once"}, bad, 0);
    quiet = 1;
    repeat (20) @(posedge clk);
    #1 quiet = 0;
  endtask

  initial begin
    int mx, gmx;
    for (int k = 0; k < 9; k++) begin
      wts[0][k] = 1;
      wts[1][k] = (k == 4) ? 1 : 0;
      wts[2][k] = (k == 4) ? 8 : -1;
    end
    quiet = 0;
    reset_mon();

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_ren", int'(ren), 0);
    chk("reset_wen", int'(wen), 0);
    chk("reset_raddr", int'(raddr), 0);
    chk("reset_waddr", int'(waddr), 0);
    chk("reset_dout", int'(data_out), 0);

    for (int i = 0; i < 784; i++) img[i] = 100;
    run_image("c100", 2, 0);
    chk("c100_ch0", mem[0], 900);
    chk("c100_ch1", mem[976], 100);
    chk("c100_ch2", mem[2027], 0);

    for (int i = 0; i < 784; i++) img[i] = 255;
    run_image("c255", 50, 0);
    chk("c255_ch0", mem[675], 2295);
    chk("c255_ch1", mem[1000], 255);
    chk("c255_ch2", mem[1400], 0);

    for (int i = 0; i < 784; i++) img[i] = 0;
    img[5 * 28 + 5] = 200;
    run_image("dot", 2, 0);
    chk("dot_ch1_centre", mem[784], 200);
    chk("dot_ch2_centre", mem[1460], 1600);
    chk("dot_ch2_neigh", mem[1461], 0);
    chk("dot_ch0_corner", mem[81], 200);
    chk("dot_ch0_far", mem[0], 0);

    for (int i = 0; i < 784; i++) img[i] = i % 256;
    run_image("ramp", 2, 0);
    mx = 0; gmx = 0;
    for (int p = 0; p < 676; p++) begin
      if (mem[p] > mx) mx = mem[p];
      if (golden(0, p / 26, p % 26) > gmx) gmx = golden(0, p / 26, p % 26);
    end
    chk("ramp_ch0_max", mx, gmx);
    chk("ramp_ch0_unsat", int'(mx < 4095), 1);

    run_image("abort", 2, 3000);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
